mem_req_ctrl: RTL

MEM_REQ_CTRL -- requirements
Module: mem_req_ctrl

---
 rtl/mem_req_ctrl.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/mem_req_ctrl.sv
// Two-requester arbiter in front of a slowmem port with at most one transaction outstanding.
// Optional feature: define MEMCTL_RETRY_EN to re-strobe a read after TIMEOUT silent WAIT cycles.
module mem_req_ctrl #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [1:0]  i_req,
    input  logic [1:0]  i_req_rnotw,
    input  logic [15:0] i_req_addr0,
    input  logic [15:0] i_req_addr1,
    input  logic [15:0] i_req_wdata0,
    input  logic [15:0] i_req_wdata1,
    output logic [1:0]  o_ack,
    output logic [15:0] o_rsp_data,
    output logic        o_busy,
    output logic        o_strobe,
    output logic        o_rnotw,
    output logic [15:0] o_addr,
    output logic [15:0] o_wdata,
    input  logic        i_mfc,
    input  logic [15:0] i_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    if (TIMEOUT == 0 || TIMEOUT > 255) begin : g_bad_timeout
        $error("mem_req_ctrl: TIMEOUT must be within 1..255");
    end

    state_t      r_state, w_state_nxt;
    logic        r_last_grant, w_last_grant_nxt;
    logic        r_pid, w_pid_nxt;
    logic        r_is_wr, w_is_wr_nxt;
    logic [1:0]  r_block, w_set_block;
    logic [7:0]  r_wait_cnt, w_wait_cnt_nxt;
    logic        w_strobe_nxt, w_rnotw_nxt, w_busy_nxt;
    logic [1:0]  w_ack_nxt;
    logic [15:0] w_addr_nxt, w_wdata_nxt, w_rsp_nxt;
    logic [1:0]  w_avail;
    logic        w_gnt_pid;
    logic        w_retry;

    // A PID that was just acked must be seen low once before it can win again.
    assign w_avail   = i_req & ~r_block;
    assign w_gnt_pid = (w_avail == 2'b11) ? ~r_last_grant : w_avail[1];

`ifdef MEMCTL_RETRY_EN
    assign w_retry = (r_wait_cnt == 8'(TIMEOUT));
`else
    assign w_retry = 1'b0;
`endif

    always_comb begin
        w_state_nxt      = r_state;
        w_last_grant_nxt = r_last_grant;
        w_pid_nxt        = r_pid;
        w_is_wr_nxt      = r_is_wr;
        w_wait_cnt_nxt   = r_wait_cnt;
        w_set_block      = 2'b00;
        w_strobe_nxt     = 1'b0;
        w_rnotw_nxt      = o_rnotw;
        w_addr_nxt       = o_addr;
        w_wdata_nxt      = o_wdata;
        w_ack_nxt        = 2'b00;
        w_rsp_nxt        = o_rsp_data;
        case (r_state)
            ST_IDLE: begin
                if (w_avail != 2'b00) begin
                    w_pid_nxt        = w_gnt_pid;
                    w_last_grant_nxt = w_gnt_pid;
                    w_strobe_nxt     = 1'b1;
                    w_rnotw_nxt      = i_req_rnotw[w_gnt_pid];
                    w_is_wr_nxt      = ~i_req_rnotw[w_gnt_pid];
                    w_addr_nxt       = w_gnt_pid ? i_req_addr1 : i_req_addr0;
                    if (!i_req_rnotw[w_gnt_pid])
                        w_wdata_nxt = w_gnt_pid ? i_req_wdata1 : i_req_wdata0;
                    w_wait_cnt_nxt   = 8'd0;
                    w_state_nxt      = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // The first WAIT cycle carries the strobe; writes complete right after it.
                if (r_is_wr || i_mfc) begin
                    if (!r_is_wr)
                        w_rsp_nxt = i_rdata;
                    w_ack_nxt             = r_pid ? 2'b10 : 2'b01;
                    w_set_block[r_pid]    = 1'b1;
                    w_state_nxt           = ST_DONE;
                end else if (w_retry) begin
                    w_strobe_nxt   = 1'b1;
                    w_wait_cnt_nxt = 8'd0;
                end else if (r_wait_cnt != 8'hFF) begin
                    w_wait_cnt_nxt = r_wait_cnt + 8'd1;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
            r_pid        <= 1'b0;
            r_is_wr      <= 1'b0;
            r_block      <= 2'b00;
            r_wait_cnt   <= 8'd0;
            o_strobe     <= 1'b0;
            o_rnotw      <= 1'b1;
            o_addr       <= 16'd0;
            o_wdata      <= 16'd0;
            o_ack        <= 2'b00;
            o_rsp_data   <= 16'd0;
            o_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_pid        <= w_pid_nxt;
            r_is_wr      <= w_is_wr_nxt;
            r_block      <= (r_block | w_set_block) & i_req;
            r_wait_cnt   <= w_wait_cnt_nxt;
            o_strobe     <= w_strobe_nxt;
            o_rnotw      <= w_rnotw_nxt;
            o_addr       <= w_addr_nxt;
            o_wdata      <= w_wdata_nxt;
            o_ack        <= w_ack_nxt;
            o_rsp_data   <= w_rsp_nxt;
            o_busy       <= w_busy_nxt;
        end
    end

endmodule
